// File: rtl/codma_rd_burst_ctrl.sv
// codma_rd_burst_ctrl: read-channel controller for the codma engine.
// Splits a read task into bus bursts of at most BURST_MAX beats, runs a
// request/grant handshake per burst and forwards read beats with one cycle
// of latency. Bus errors park the controller in RD_ERROR until err_clear.
// Optional build macro RD_TIMEOUT_EN adds a stall watchdog (TIMEOUT_CYC).

module codma_rd_burst_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int BURST_MAX   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              err_clear,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              bus_req,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [LEN_W-1:0]  bus_len,
    input  logic              bus_gnt,
    input  logic              bus_rd_valid,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_err,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_last
);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'b00,
        RD_ASK     = 2'b01,
        RD_GRANTED = 2'b10,
        RD_ERROR   = 2'b11
    } rd_state_t;

    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [LEN_W-1:0]  BURST_LEN  = LEN_W'(BURST_MAX);
    localparam logic [LEN_W-1:0]  ONE_WORD   = LEN_W'(1);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BUS      = 2'b01;
    localparam logic [1:0] ERR_GNT_TO   = 2'b10;
    localparam logic [1:0] ERR_DATA_TO  = 2'b11;

    rd_state_t         state;
    rd_state_t         next_state;

    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [LEN_W-1:0]  bus_len_q;
    logic              data_valid_q;
    logic [DATA_W-1:0] data_out_q;
    logic              data_last_q;
    logic              done_q;
    logic [1:0]        err_code_q;

    logic              task_load;
    logic              zero_task;
    logic              beat_fire;
    logic              burst_end;
    logic              final_beat;
    logic              err_set;
    logic [1:0]        err_val;
    logic              stall_hit;

    logic [ADDR_W-1:0] addr_inc;
    logic [LEN_W-1:0]  remaining_dec;
    logic [LEN_W-1:0]  beat_cnt_inc;

    function automatic logic [LEN_W-1:0] clip_len(input logic [LEN_W-1:0] words);
        return (words > BURST_LEN) ? BURST_LEN : words;
    endfunction

    assign addr_inc      = cur_addr + BEAT_BYTES;
    assign remaining_dec = remaining - ONE_WORD;
    assign beat_cnt_inc  = beat_cnt + ONE_WORD;

`ifdef RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stalling;

    assign stalling  = ((state == RD_ASK) && !bus_gnt) ||
                       ((state == RD_GRANTED) && !bus_rd_valid && !bus_err);
    assign stall_hit = stalling && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Watchdog: counts consecutive stalled cycles, restarting on progress or state change
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!stalling || (next_state != state)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`else
    assign stall_hit = 1'b0;

    // TIMEOUT_CYC has no effect without the watchdog; referenced so every build elaborates it
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        next_state = state;
        task_load  = 1'b0;
        zero_task  = 1'b0;
        beat_fire  = 1'b0;
        burst_end  = 1'b0;
        final_beat = 1'b0;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        case (state)
            RD_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        task_load  = 1'b1;
                        next_state = RD_ASK;
                    end else begin
                        zero_task = 1'b1;
                    end
                end
            end
            RD_ASK: begin
                if (bus_gnt) begin
                    next_state = RD_GRANTED;
                end else if (stall_hit) begin
                    err_set    = 1'b1;
                    err_val    = ERR_GNT_TO;
                    next_state = RD_ERROR;
                end
            end
            RD_GRANTED: begin
                if (bus_err) begin
                    err_set    = 1'b1;
                    err_val    = ERR_BUS;
                    next_state = RD_ERROR;
                end else if (bus_rd_valid) begin
                    beat_fire = 1'b1;
                    if (beat_cnt_inc == bus_len_q) begin
                        burst_end = 1'b1;
                        if (remaining == ONE_WORD) begin
                            final_beat = 1'b1;
                            next_state = RD_IDLE;
                        end else begin
                            next_state = RD_ASK;
                        end
                    end
                end else if (stall_hit) begin
                    err_set    = 1'b1;
                    err_val    = ERR_DATA_TO;
                    next_state = RD_ERROR;
                end
            end
            RD_ERROR: begin
                if (err_clear) begin
                    next_state = RD_IDLE;
                end
            end
            default: next_state = RD_IDLE;
        endcase
    end

    // Task bookkeeping: address, remaining words, beat count and burst descriptor
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr   <= '0;
            remaining  <= '0;
            beat_cnt   <= '0;
            bus_addr_q <= '0;
            bus_len_q  <= '0;
        end else if (task_load) begin
            cur_addr   <= start_addr;
            remaining  <= num_words;
            beat_cnt   <= '0;
            bus_addr_q <= start_addr;
            bus_len_q  <= clip_len(num_words);
        end else if (beat_fire) begin
            cur_addr  <= addr_inc;
            remaining <= remaining_dec;
            if (burst_end) begin
                beat_cnt   <= '0;
                bus_addr_q <= addr_inc;
                bus_len_q  <= clip_len(remaining_dec);
            end else begin
                beat_cnt <= beat_cnt_inc;
            end
        end
    end

    // Registered beat forward plus completion pulse and error code
    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            data_last_q  <= 1'b0;
            done_q       <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            data_valid_q <= beat_fire;
            data_last_q  <= final_beat;
            done_q       <= final_beat || zero_task;
            if (beat_fire) begin
                data_out_q <= bus_rd_data;
            end
            if (err_set) begin
                err_code_q <= err_val;
            end else if ((state == RD_ERROR) && err_clear) begin
                err_code_q <= ERR_NONE;
            end
        end
    end

    assign busy       = (state != RD_IDLE);
    assign error      = (state == RD_ERROR);
    assign bus_req    = (state == RD_ASK);
    assign bus_addr   = bus_addr_q;
    assign bus_len    = bus_len_q;
    assign err_code   = err_code_q;
    assign done       = done_q;
    assign data_valid = data_valid_q;
    assign data_out   = data_out_q;
    assign data_last  = data_last_q;

endmodule

// File: tb/tb_codma_rd_burst_ctrl.sv
// tb_codma_rd_burst_ctrl: directed self-checking bench for codma_rd_burst_ctrl
// with BURST_MAX=4 and TIMEOUT_CYC=8; timeout steps follow RD_TIMEOUT_EN.

module tb_codma_rd_burst_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] start_addr;
    logic [7:0]  num_words;
    logic        err_clear;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic        bus_gnt;
    logic        bus_rd_valid;
    logic [31:0] bus_rd_data;
    logic        bus_err;
    logic        data_valid;
    logic [31:0] data_out;
    logic        data_last;

    int tests_run = 0;
    int tests_failed = 0;

    codma_rd_burst_ctrl #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(8), .BURST_MAX(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .num_words(num_words), .err_clear(err_clear), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_len(bus_len), .bus_gnt(bus_gnt), .bus_rd_valid(bus_rd_valid),
        .bus_rd_data(bus_rd_data), .bus_err(bus_err), .data_valid(data_valid),
        .data_out(data_out), .data_last(data_last)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_err_code"}, err_code, 0);
        checkOutput({tag, "_bus_req"}, bus_req, 0);
        checkOutput({tag, "_bus_addr"}, bus_addr, 0);
        checkOutput({tag, "_bus_len"}, bus_len, 0);
        checkOutput({tag, "_data_valid"}, data_valid, 0);
        checkOutput({tag, "_data_out"}, data_out, 0);
        checkOutput({tag, "_data_last"}, data_last, 0);
    endtask

    // Full task with a simple bus model: grant after gnt_delay request cycles,
    // back-to-back beats while granted, junk beats while requesting
    task automatic applyStimulus(input logic [31:0] addr, input int n, input int gnt_delay);
        int beats_seen = 0;
        int bursts = 0;
        int req_cycles = 0;
        int sent = 0;
        int rem;
        bit gnt_prev = 0;
        bit finished = 0;
        logic [31:0] exp_a = '0;
        logic [7:0]  exp_l = '0;
        logic [31:0] base;
        base = {addr[15:0], 16'h0000};
        start = 1'b1;
        start_addr = addr;
        num_words = 8'(n);
        bus_gnt = 1'b0;
        bus_rd_valid = 1'b0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            nextCycle();
            start = 1'b0;
            if (gnt_prev) checkOutput("req_drop_after_gnt", bus_req, 0);
            if (bus_req) begin
                if (req_cycles == 0) begin
                    rem = n - bursts * 4;
                    exp_a = addr + 32'(bursts * 16);
                    exp_l = 8'((rem < 4) ? rem : 4);
                    bursts++;
                end
                checkOutput("burst_addr", bus_addr, exp_a);
                checkOutput("burst_len", bus_len, exp_l);
                req_cycles++;
            end else begin
                req_cycles = 0;
            end
            if (data_valid) begin
                checkOutput("beat_data", data_out, base + 32'(beats_seen));
                checkOutput("beat_last", data_last, (beats_seen == n - 1));
                checkOutput("beat_done", done, (beats_seen == n - 1));
                if (beats_seen == n - 1) finished = 1;
                beats_seen++;
            end else begin
                checkOutput("no_early_done", done, 0);
            end
            checkOutput("no_error", error, 0);
            bus_gnt = bus_req && (req_cycles > gnt_delay);
            gnt_prev = bus_gnt;
            if (busy && !bus_req && sent < n) begin
                bus_rd_valid = 1'b1;
                bus_rd_data = base + 32'(sent);
                sent++;
            end else if (bus_req) begin
                bus_rd_valid = 1'b1;
                bus_rd_data = 32'hDEAD_BEEF;
            end else begin
                bus_rd_valid = 1'b0;
            end
        end
        checkOutput("task_finished", finished, 1);
        checkOutput("burst_count", bursts, (n + 3) / 4);
        checkOutput("beat_count", beats_seen, n);
        bus_rd_valid = 1'b0;
        bus_gnt = 1'b0;
        nextCycle();
        checkOutput("busy_after_done", busy, 0);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("valid_after_done", data_valid, 0);
    endtask

    // Directed sequence
    initial begin
        reset = 1'b1;
        start = 1'b0;
        start_addr = '0;
        num_words = '0;
        err_clear = 1'b0;
        bus_gnt = 1'b0;
        bus_rd_valid = 1'b0;
        bus_rd_data = '0;
        bus_err = 1'b0;
        nextCycle();
        nextCycle();
        reset = 1'b0;
        checkResetOutputs("reset");

        // Ten words from 0x1000: bursts (0x1000,4) (0x1010,4) (0x1020,2)
        applyStimulus(32'h0000_1000, 10, 0);

        // Zero-length task: done one cycle after start, no bus activity
        start = 1'b1;
        num_words = 8'd0;
        start_addr = 32'h0000_4000;
        nextCycle();
        start = 1'b0;
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        checkOutput("zero_req", bus_req, 0);
        nextCycle();
        checkOutput("zero_done_drop", done, 0);
        checkOutput("zero_busy2", busy, 0);
        checkOutput("zero_req2", bus_req, 0);

        // Grant withheld for five request cycles
        applyStimulus(32'h0000_2000, 6, 5);

        // Bus error on beat 2 of a 4-beat burst
        start = 1'b1;
        start_addr = 32'h0000_3000;
        num_words = 8'd4;
        nextCycle();
        start = 1'b0;
        checkOutput("berr_req", bus_req, 1);
        checkOutput("berr_len", bus_len, 4);
        bus_gnt = 1'b1;
        nextCycle();
        checkOutput("berr_req_drop", bus_req, 0);
        bus_gnt = 1'b0;
        bus_rd_valid = 1'b1;
        bus_rd_data = 32'h0000_00B1;
        nextCycle();
        checkOutput("berr_beat1_valid", data_valid, 1);
        checkOutput("berr_beat1_data", data_out, 32'h0000_00B1);
        bus_rd_data = 32'h0000_00B2;
        bus_err = 1'b1;
        nextCycle();
        checkOutput("berr_error", error, 1);
        checkOutput("berr_code", err_code, 2'b01);
        checkOutput("berr_beat2_dropped", data_valid, 0);
        checkOutput("berr_busy", busy, 1);
        bus_rd_valid = 1'b0;
        bus_err = 1'b0;
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkOutput("berr_start_ignored", error, 1);
        checkOutput("berr_no_req", bus_req, 0);
        checkOutput("berr_no_valid", data_valid, 0);
        err_clear = 1'b1;
        nextCycle();
        err_clear = 1'b0;
        checkOutput("berr_cleared", error, 0);
        checkOutput("berr_code_cleared", err_code, 2'b00);
        checkOutput("berr_idle", busy, 0);
        applyStimulus(32'h0000_3100, 3, 0);

        // Address wrap past the top of memory
        applyStimulus(32'hFFFF_FFF8, 4, 0);
        applyStimulus(32'hFFFF_FFF8, 6, 1);

        // Reset in the middle of a burst; later beats ignored
        start = 1'b1;
        start_addr = 32'h0000_6000;
        num_words = 8'd8;
        nextCycle();
        start = 1'b0;
        bus_gnt = 1'b1;
        nextCycle();
        bus_gnt = 1'b0;
        bus_rd_valid = 1'b1;
        bus_rd_data = 32'h0000_00C1;
        nextCycle();
        bus_rd_data = 32'h0000_00C2;
        nextCycle();
        checkOutput("rst_mid_pre_valid", data_valid, 1);
        reset = 1'b1;
        bus_rd_data = 32'h0000_00C3;
        nextCycle();
        checkResetOutputs("rst_mid");
        reset = 1'b0;
        bus_rd_data = 32'h0000_00C4;
        nextCycle();
        checkOutput("rst_beat_ignored", data_valid, 0);
        checkOutput("rst_idle", busy, 0);
        bus_rd_valid = 1'b0;

`ifdef RD_TIMEOUT_EN
        // Grant never arrives: error after eight request cycles
        start = 1'b1;
        start_addr = 32'h0000_7000;
        num_words = 8'd4;
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            start = 1'b0;
            checkOutput("gto_waiting", bus_req, 1);
        end
        nextCycle();
        checkOutput("gto_error", error, 1);
        checkOutput("gto_code", err_code, 2'b10);
        err_clear = 1'b1;
        nextCycle();
        err_clear = 1'b0;
        checkOutput("gto_cleared", busy, 0);

        // Grant given but no beats: error after eight granted cycles
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        bus_gnt = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            nextCycle();
            bus_gnt = 1'b0;
            checkOutput("dto_waiting", busy && !bus_req && !error, 1);
        end
        nextCycle();
        checkOutput("dto_error", error, 1);
        checkOutput("dto_code", err_code, 2'b11);
        err_clear = 1'b1;
        nextCycle();
        err_clear = 1'b0;
        checkOutput("dto_code_cleared", err_code, 2'b00);
`else
        // Without the watchdog a long grant stall simply waits
        applyStimulus(32'h0000_5000, 3, 20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
